mprj_checkpoint_monitor: RTL

- Synthesizable, parametrised checkpoint sequencer. Watches a user-project check bus (e.g. mprj_io[31:16]) for a programmed ordered sequence of up to DEPTH masked expected values.
- Each step has a per-step cycle timeout. Result is reported as pass/fail with a reason code.
- Generalises the fixed two-value (16'hAB60 → 16'hAB61) wait-plus-global-timeout check into a configurable sequence with width, depth, mask and strict mode.
- Sits in the user project area. Driven by firmware through a simple config-write port; results are observable on LA/GPIO.

---
 rtl/mprj_checkpoint_monitor.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mprj_checkpoint_monitor.sv
// Ordered masked-checkpoint sequencer with per-step timeout and strict-order mode.
// Define CHKMON_STAMP_EN to record a run-relative timestamp for every step hit.
module mprj_checkpoint_monitor #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int TW    = 24,
    parameter int SW    = $clog2(DEPTH+1)
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic [WIDTH-1:0]         checkbits,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [WIDTH-1:0]         cfg_exp,
    input  logic [WIDTH-1:0]         cfg_mask,
    input  logic [SW-1:0]            num_steps,
    input  logic [TW-1:0]            timeout_cycles,
    input  logic                     strict,
    input  logic                     start,
    input  logic                     clear,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [1:0]               fail_code,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic [WIDTH-1:0]         fail_value,
    input  logic [$clog2(DEPTH)-1:0] stamp_addr,
    output logic [TW-1:0]            stamp_data
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd1;
    localparam logic [1:0] CODE_MISMATCH = 2'd2;
    localparam logic [1:0] CODE_CONFIG   = 2'd3;

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    step_q, step_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic [1:0]       code_q, code_nxt;
    logic [WIDTH-1:0] fval_q, fval_nxt;

    logic [WIDTH-1:0] exp_tab  [DEPTH];
    logic [WIDTH-1:0] mask_tab [DEPTH];

    logic          hit_cur, hit_prev, cfg_ok, last_step;
    logic [AW-1:0] prev_idx;

    assign prev_idx  = step_q - AW'(1);
    assign hit_cur   = ((checkbits ^ exp_tab[step_q]) & mask_tab[step_q]) == '0;
    assign hit_prev  = ((checkbits ^ exp_tab[prev_idx]) & mask_tab[prev_idx]) == '0;
    assign cfg_ok    = (num_steps != '0) && (num_steps <= SW'(DEPTH));
    assign last_step = (SW'(step_q) + SW'(1)) == num_steps;

    always_ff @(posedge clock) begin
        if (!resetb) begin
            state  <= IDLE;
            step_q <= '0;
            timer  <= '0;
            code_q <= CODE_NONE;
            fval_q <= '0;
        end else begin
            state  <= state_nxt;
            step_q <= step_nxt;
            timer  <= timer_nxt;
            code_q <= code_nxt;
            fval_q <= fval_nxt;
        end
    end

    // In RUN a step hit outranks strict mismatch, which outranks the timeout.
    always_comb begin
        state_nxt = state;
        step_nxt  = step_q;
        timer_nxt = timer;
        code_nxt  = code_q;
        fval_nxt  = fval_q;
        if (clear) begin
            state_nxt = IDLE;
            step_nxt  = '0;
            timer_nxt = '0;
            code_nxt  = CODE_NONE;
            fval_nxt  = '0;
        end else if (state != RUN) begin
            if (start) begin
                step_nxt  = '0;
                timer_nxt = '0;
                if (cfg_ok) begin
                    state_nxt = RUN;
                    code_nxt  = CODE_NONE;
                    fval_nxt  = '0;
                end else begin
                    state_nxt = FAIL;
                    code_nxt  = CODE_CONFIG;
                    fval_nxt  = checkbits;
                end
            end
        end else begin
            if (hit_cur) begin
                if (last_step) begin
                    state_nxt = PASS;
                end else begin
                    step_nxt  = step_q + AW'(1);
                    timer_nxt = '0;
                end
            end else if (strict && (step_q != '0) && !hit_prev) begin
                state_nxt = FAIL;
                code_nxt  = CODE_MISMATCH;
                fval_nxt  = checkbits;
            end else if ((timeout_cycles != '0) && (timer == timeout_cycles - TW'(1))) begin
                state_nxt = FAIL;
                code_nxt  = CODE_TIMEOUT;
                fval_nxt  = checkbits;
            end else if (timer != '1) begin
                timer_nxt = timer + TW'(1);
            end
        end
    end

    // Tables survive clear; only reset wipes them, and RUN locks them.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            for (int i = 0; i < DEPTH; i++) begin
                exp_tab[i]  <= '0;
                mask_tab[i] <= '0;
            end
        end else if (cfg_we && (state != RUN)) begin
            exp_tab[cfg_addr]  <= cfg_exp;
            mask_tab[cfg_addr] <= cfg_mask;
        end
    end

    assign busy       = (state == RUN);
    assign done       = (state == PASS) || (state == FAIL);
    assign pass       = (state == PASS);
    assign fail_code  = code_q;
    assign step_idx   = step_q;
    assign fail_value = fval_q;

`ifdef CHKMON_STAMP_EN
    logic [TW-1:0] run_cnt;
    logic [TW-1:0] stamp_tab [DEPTH];

    // run_cnt reads 0 on the first RUN cycle because it is held at 0 outside RUN.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            run_cnt    <= '0;
            stamp_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stamp_tab[i] <= '0;
            end
        end else begin
            stamp_data <= clear ? '0 : stamp_tab[stamp_addr];
            if (state != RUN) begin
                run_cnt <= '0;
                if (start && !clear) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stamp_tab[i] <= '0;
                    end
                end
            end else begin
                if (run_cnt != '1) begin
                    run_cnt <= run_cnt + TW'(1);
                end
                if (hit_cur && !clear) begin
                    stamp_tab[step_q] <= run_cnt;
                end
            end
        end
    end
`else
    logic unused_stamp_addr;
    assign unused_stamp_addr = ^stamp_addr;
    assign stamp_data        = '0;
`endif

endmodule
